// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32IM pipelined control unit: opcodes, ALU operation codes,
// memory/branch sub-op codes, FSM states and the packed control bundle.
package rv32_ctrl_pkg;

  localparam int ALUOP_BITS = 5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [ALUOP_BITS-1:0] ALU_PASS   = 5'b00000;
  localparam logic [ALUOP_BITS-1:0] ALU_ADD    = 5'b00001;
  localparam logic [ALUOP_BITS-1:0] ALU_AND    = 5'b00010;
  localparam logic [ALUOP_BITS-1:0] ALU_OR     = 5'b00011;
  localparam logic [ALUOP_BITS-1:0] ALU_XOR    = 5'b00100;
  localparam logic [ALUOP_BITS-1:0] ALU_SLL    = 5'b00101;
  localparam logic [ALUOP_BITS-1:0] ALU_SRL    = 5'b00110;
  localparam logic [ALUOP_BITS-1:0] ALU_SRA    = 5'b00111;
  localparam logic [ALUOP_BITS-1:0] ALU_SUB    = 5'b01000;
  localparam logic [ALUOP_BITS-1:0] ALU_MUL    = 5'b01001;
  localparam logic [ALUOP_BITS-1:0] ALU_MULH   = 5'b01010;
  localparam logic [ALUOP_BITS-1:0] ALU_MULHU  = 5'b01011;
  localparam logic [ALUOP_BITS-1:0] ALU_MULHSU = 5'b01100;
  localparam logic [ALUOP_BITS-1:0] ALU_DIV    = 5'b01101;
  localparam logic [ALUOP_BITS-1:0] ALU_DIVU   = 5'b01110;
  localparam logic [ALUOP_BITS-1:0] ALU_REM    = 5'b01111;
  localparam logic [ALUOP_BITS-1:0] ALU_REMU   = 5'b10000;
  localparam logic [ALUOP_BITS-1:0] ALU_SLT    = 5'b10001;
  localparam logic [ALUOP_BITS-1:0] ALU_SLTU   = 5'b10010;

  localparam logic [2:0] LS_LB = 3'd1, LS_LH = 3'd2, LS_LW = 3'd3;
  localparam logic [2:0] LS_LBU = 3'd4, LS_LHU = 3'd5, LS_UPPER = 3'd6;
  localparam logic [1:0] SS_SB = 2'd1, SS_SH = 2'd2, SS_SW = 2'd3;
  localparam logic [2:0] BS_BEQ = 3'd1, BS_BNE = 3'd2, BS_BLT = 3'd3;
  localparam logic [2:0] BS_BGE = 3'd4, BS_BLTU = 3'd5, BS_BGEU = 3'd6;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MDIV = 1'b1
  } state_t;

  typedef struct packed {
    logic [ALUOP_BITS-1:0] aluop;
    logic                  immflag;
    logic                  jumpflag;
    logic                  selectwrite;
    logic                  writeenable;
    logic                  read;
    logic                  write;
    logic [2:0]            loadsignal;
    logic [1:0]            storesignal;
    logic [2:0]            branchsignal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// IF/ID-side inputs and ID/EX control outputs of the pipelined control unit.
interface pipelined_control_unit_if #(
  parameter int ALUOP_W = 5
);
  logic               instr_valid;
  logic [6:0]         opcode;
  logic [2:0]         func3;
  logic [6:0]         func7;
  logic               busywait;
  logic               flush;
  logic [ALUOP_W-1:0] aluop;
  logic               immflag;
  logic               jumpflag;
  logic               selectwrite;
  logic               writeenable;
  logic               read;
  logic               write;
  logic [2:0]         loadsignal;
  logic [1:0]         storesignal;
  logic [2:0]         branchsignal;
  logic               valid_out;
  logic               stall;
  logic               mdiv_busy;
  logic               illegal;

  modport master (
    output instr_valid, opcode, func3, func7, busywait, flush,
    input  aluop, immflag, jumpflag, selectwrite, writeenable, read, write,
           loadsignal, storesignal, branchsignal, valid_out, stall, mdiv_busy, illegal
  );

  modport slave (
    input  instr_valid, opcode, func3, func7, busywait, flush,
    output aluop, immflag, jumpflag, selectwrite, writeenable, read, write,
           loadsignal, storesignal, branchsignal, valid_out, stall, mdiv_busy, illegal
  );
endinterface

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32IM decode table: opcode/func3/func7 to control bundle,
// M-extension class flags and an illegal-encoding flag.
module rv32_decode_comb
  import rv32_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output ctrl_t      ctrl,
  output logic       is_mul,
  output logic       is_div,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ctrl.read        = 1'b1;
        ctrl.selectwrite = 1'b1;
        ctrl.writeenable = 1'b1;
        ctrl.immflag     = 1'b1;
        case (func3)
          3'b000:  ctrl.loadsignal = LS_LB;
          3'b001:  ctrl.loadsignal = LS_LH;
          3'b010:  ctrl.loadsignal = LS_LW;
          3'b100:  ctrl.loadsignal = LS_LBU;
          3'b101:  ctrl.loadsignal = LS_LHU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl.write   = 1'b1;
        ctrl.immflag = 1'b1;
        case (func3)
          3'b000:  ctrl.storesignal = SS_SB;
          3'b001:  ctrl.storesignal = SS_SH;
          3'b010:  ctrl.storesignal = SS_SW;
          default: illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        case (func3)
          3'b000:  begin ctrl.aluop = ALU_SUB;  ctrl.branchsignal = BS_BEQ;  end
          3'b001:  begin ctrl.aluop = ALU_SUB;  ctrl.branchsignal = BS_BNE;  end
          3'b100:  begin ctrl.aluop = ALU_SLT;  ctrl.branchsignal = BS_BLT;  end
          3'b101:  begin ctrl.aluop = ALU_SLT;  ctrl.branchsignal = BS_BGE;  end
          3'b110:  begin ctrl.aluop = ALU_SLTU; ctrl.branchsignal = BS_BLTU; end
          3'b111:  begin ctrl.aluop = ALU_SLTU; ctrl.branchsignal = BS_BGEU; end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl.aluop       = (opcode == OPC_AUIPC) ? ALU_ADD : ALU_PASS;
        ctrl.immflag     = 1'b1;
        ctrl.writeenable = 1'b1;
        ctrl.loadsignal  = LS_UPPER;
      end
      OPC_JAL: begin
        ctrl.jumpflag    = 1'b1;
        ctrl.writeenable = 1'b1;
      end
      OPC_JALR: begin
        ctrl.jumpflag    = 1'b1;
        ctrl.writeenable = 1'b1;
        ctrl.immflag     = 1'b1;
        illegal          = (func3 != 3'b000);
      end
      OPC_OPIMM: begin
        ctrl.immflag     = 1'b1;
        ctrl.writeenable = 1'b1;
        // Shift-immediates reuse func7 as an encoding field; the rest treat it as immediate bits.
        case (func3)
          3'b000: ctrl.aluop = ALU_ADD;
          3'b010: ctrl.aluop = ALU_SLT;
          3'b011: ctrl.aluop = ALU_SLTU;
          3'b100: ctrl.aluop = ALU_XOR;
          3'b110: ctrl.aluop = ALU_OR;
          3'b111: ctrl.aluop = ALU_AND;
          3'b001: begin ctrl.aluop = ALU_SLL; illegal = (func7 != F7_BASE); end
          default: begin
            if (func7 == F7_BASE)     ctrl.aluop = ALU_SRL;
            else if (func7 == F7_ALT) ctrl.aluop = ALU_SRA;
            else                      illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        ctrl.writeenable = 1'b1;
        case (func7)
          F7_BASE: begin
            case (func3)
              3'b000:  ctrl.aluop = ALU_ADD;
              3'b001:  ctrl.aluop = ALU_SLL;
              3'b010:  ctrl.aluop = ALU_SLT;
              3'b011:  ctrl.aluop = ALU_SLTU;
              3'b100:  ctrl.aluop = ALU_XOR;
              3'b101:  ctrl.aluop = ALU_SRL;
              3'b110:  ctrl.aluop = ALU_OR;
              default: ctrl.aluop = ALU_AND;
            endcase
          end
          F7_ALT: begin
            if (func3 == 3'b000)      ctrl.aluop = ALU_SUB;
            else if (func3 == 3'b101) ctrl.aluop = ALU_SRA;
            else                      illegal = 1'b1;
          end
          F7_MEXT: begin
            if (ENABLE_M) begin
              is_mul = ~func3[2];
              is_div = func3[2];
              case (func3)
                3'b000:  ctrl.aluop = ALU_MUL;
                3'b001:  ctrl.aluop = ALU_MULH;
                3'b010:  ctrl.aluop = ALU_MULHSU;
                3'b011:  ctrl.aluop = ALU_MULHU;
                3'b100:  ctrl.aluop = ALU_DIV;
                3'b101:  ctrl.aluop = ALU_DIVU;
                3'b110:  ctrl.aluop = ALU_REM;
                default: ctrl.aluop = ALU_REMU;
              endcase
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered RV32IM control unit: ID/EX control register, multi-cycle M-op stall FSM,
// memory busy freeze, flush bubbling and illegal-instruction pulse.
module pipelined_control_unit
  import rv32_ctrl_pkg::*;
#(
  parameter int ALUOP_W  = 5,
  parameter int MUL_LAT  = 1,
  parameter int DIV_LAT  = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_control_unit_if.slave bus
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  ctrl_t            dec_ctrl;
  logic             dec_is_mul;
  logic             dec_is_div;
  logic             dec_illegal;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  ctrl_t            ctrl_reg;
  logic             valid_reg;
  logic             illegal_reg;

  rv32_decode_comb #(.ENABLE_M(ENABLE_M)) u_decode (
    .opcode (bus.opcode),
    .func3  (bus.func3),
    .func7  (bus.func7),
    .ctrl   (dec_ctrl),
    .is_mul (dec_is_mul),
    .is_div (dec_is_div),
    .illegal(dec_illegal)
  );

  // BUSYWAIT outranks everything but reset; FLUSH is only seen in RUN, so an
  // in-flight M-op always completes before the younger ID instruction is killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_RUN;
      cnt_reg     <= '0;
      ctrl_reg    <= CTRL_NOP;
      valid_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else if (!bus.busywait) begin
      case (state_reg)
        ST_RUN: begin
          ctrl_reg    <= CTRL_NOP;
          valid_reg   <= 1'b0;
          illegal_reg <= 1'b0;
          if (bus.instr_valid && !bus.flush) begin
            if (dec_illegal) begin
              illegal_reg <= 1'b1;
            end else begin
              ctrl_reg  <= dec_ctrl;
              valid_reg <= 1'b1;
              if (dec_is_mul && (MUL_LAT > 1)) begin
                state_reg <= ST_MDIV;
                cnt_reg   <= MUL_CNT;
              end
              if (dec_is_div && (DIV_LAT > 1)) begin
                state_reg <= ST_MDIV;
                cnt_reg   <= DIV_CNT;
              end
            end
          end
        end
        ST_MDIV: begin
          if (cnt_reg <= CNT_ONE) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign bus.aluop        = ALUOP_W'(ctrl_reg.aluop);
  assign bus.immflag      = ctrl_reg.immflag;
  assign bus.jumpflag     = ctrl_reg.jumpflag;
  assign bus.selectwrite  = ctrl_reg.selectwrite;
  assign bus.writeenable  = ctrl_reg.writeenable;
  assign bus.read         = ctrl_reg.read;
  assign bus.write        = ctrl_reg.write;
  assign bus.loadsignal   = ctrl_reg.loadsignal;
  assign bus.storesignal  = ctrl_reg.storesignal;
  assign bus.branchsignal = ctrl_reg.branchsignal;
  assign bus.valid_out    = valid_reg;
  assign bus.illegal      = illegal_reg;
  assign bus.mdiv_busy    = (state_reg == ST_MDIV);
  assign bus.stall        = bus.busywait || (state_reg == ST_MDIV);

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: one M-enabled instance (MUL_LAT=1, DIV_LAT=4)
// and one ENABLE_M=0 instance sharing the same instruction stream.
module tb_pipelined_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   n;

  always #5 clk = ~clk;

  pipelined_control_unit_if #(.ALUOP_W(5)) bus ();
  pipelined_control_unit_if #(.ALUOP_W(5)) bus_nom ();

  assign bus_nom.instr_valid = bus.instr_valid;
  assign bus_nom.opcode      = bus.opcode;
  assign bus_nom.func3       = bus.func3;
  assign bus_nom.func7       = bus.func7;
  assign bus_nom.busywait    = bus.busywait;
  assign bus_nom.flush       = bus.flush;

  pipelined_control_unit #(.ALUOP_W(5), .MUL_LAT(1), .DIV_LAT(4), .ENABLE_M(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  pipelined_control_unit #(.ALUOP_W(5), .MUL_LAT(1), .DIV_LAT(4), .ENABLE_M(1'b0)) dut_nom (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_nom)
  );

  logic [18:0] ctl;
  assign ctl = {bus.aluop, bus.immflag, bus.jumpflag, bus.selectwrite, bus.writeenable,
                bus.read, bus.write, bus.loadsignal, bus.storesignal, bus.branchsignal};

  // flags = {immflag, jumpflag, selectwrite, writeenable, read, write}
  function automatic logic [18:0] mk(input logic [4:0] alu, input logic [5:0] flags,
                                     input logic [2:0] ls, input logic [1:0] ss,
                                     input logic [2:0] bs);
    return {alu, flags, ls, ss, bs};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input string name, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7);
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.func3       = f3;
    bus.func7       = f7;
    $display("step %s op=%b f3=%b f7=%b", name, op, f3, f7);
  endtask

  localparam logic [18:0] ADD_CTL = 19'b00001_000100_000_00_000;
  localparam logic [18:0] DIV_CTL = 19'b01101_000100_000_00_000;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    bus.busywait = 1'b0;
    bus.flush    = 1'b0;
    ins("ADD in reset", 7'b0110011, 3'b000, 7'b0000000);
    tick(); tick();
    chk("rst_ctl", 32'(ctl), 32'd0);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_mdiv", 32'(bus.mdiv_busy), 32'd0);

    rst_n = 1'b1;
    tick();
    chk("add_ctl", 32'(ctl), 32'(ADD_CTL));
    chk("add_valid", 32'(bus.valid_out), 32'd1);

    ins("ADDI", 7'b0010011, 3'b000, 7'b0101010); tick();
    chk("addi_ctl", 32'(ctl), 32'(mk(5'b00001, 6'b100100, 3'd0, 2'd0, 3'd0)));
    ins("LW", 7'b0000011, 3'b010, 7'b0000000); tick();
    chk("lw_ctl", 32'(ctl), 32'(mk(5'b00000, 6'b101110, 3'd3, 2'd0, 3'd0)));
    ins("SB", 7'b0100011, 3'b000, 7'b0000000); tick();
    chk("sb_ctl", 32'(ctl), 32'(mk(5'b00000, 6'b100001, 3'd0, 2'd1, 3'd0)));
    ins("SRA", 7'b0110011, 3'b101, 7'b0100000); tick();
    chk("sra_ctl", 32'(ctl), 32'(mk(5'b00111, 6'b000100, 3'd0, 2'd0, 3'd0)));
    ins("BGEU", 7'b1100011, 3'b111, 7'b0000000); tick();
    chk("bgeu_ctl", 32'(ctl), 32'(mk(5'b10010, 6'b000000, 3'd0, 2'd0, 3'd6)));
    ins("AUIPC", 7'b0010111, 3'b000, 7'b0000000); tick();
    chk("auipc_ctl", 32'(ctl), 32'(mk(5'b00001, 6'b100100, 3'd6, 2'd0, 3'd0)));
    ins("JAL", 7'b1101111, 3'b000, 7'b0000000); tick();
    chk("jal_ctl", 32'(ctl), 32'(mk(5'b00000, 6'b010100, 3'd0, 2'd0, 3'd0)));

    ins("MUL", 7'b0110011, 3'b000, 7'b0000001); tick();
    chk("mul_ctl", 32'(ctl), 32'(mk(5'b01001, 6'b000100, 3'd0, 2'd0, 3'd0)));
    chk("mul_nostall", 32'(bus.stall), 32'd0);
    chk("mul_nobusy", 32'(bus.mdiv_busy), 32'd0);
    chk("nom_mul_illegal", 32'(bus_nom.illegal), 32'd1);
    chk("nom_mul_valid", 32'(bus_nom.valid_out), 32'd0);

    ins("DIV", 7'b0110011, 3'b100, 7'b0000001); tick();
    chk("div_ctl", 32'(ctl), 32'(DIV_CTL));
    ins("OR after DIV", 7'b0110011, 3'b110, 7'b0000000);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.stall) break;
      n++;
      chk("div_hold_alu", 32'(bus.aluop), 32'(5'b01101));
      chk("div_busy", 32'(bus.mdiv_busy), 32'd1);
      tick();
    end
    chk("div_stall_cycles", 32'(n), 32'd3);
    chk("div_busy_end", 32'(bus.mdiv_busy), 32'd0);
    chk("div_last_ex", 32'(bus.aluop), 32'(5'b01101));
    tick();
    chk("or_after_div", 32'(bus.aluop), 32'(5'b00011));

    ins("DIV with busywait", 7'b0110011, 3'b100, 7'b0000001); tick();
    ins("ADD after DIV", 7'b0110011, 3'b000, 7'b0000000);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.stall) break;
      n++;
      if (i == 3) chk("bw_frozen_ctl", 32'(ctl), 32'(DIV_CTL));
      if (i == 3) chk("bw_frozen_busy", 32'(bus.mdiv_busy), 32'd1);
      bus.busywait = (i >= 1 && i <= 5);
      tick();
    end
    bus.busywait = 1'b0;
    chk("bw_stall_total", 32'(n), 32'd8);
    tick();
    chk("add_after_bw", 32'(ctl), 32'(ADD_CTL));

    ins("LW then busywait", 7'b0000011, 3'b010, 7'b0000000); tick();
    bus.busywait = 1'b1;
    ins("ADD behind busy", 7'b0110011, 3'b000, 7'b0000000);
    tick(); tick();
    chk("bw_read_held", 32'(bus.read), 32'd1);
    chk("bw_stall", 32'(bus.stall), 32'd1);
    bus.busywait = 1'b0;
    #1;
    chk("bw_fall_read", 32'(bus.read), 32'd1);
    tick();
    chk("read_cleared", 32'(bus.read), 32'd0);
    chk("bw_add_ctl", 32'(ctl), 32'(ADD_CTL));

    ins("BEQ flushed", 7'b1100011, 3'b000, 7'b0000000);
    bus.flush = 1'b1;
    tick();
    chk("flush_ctl", 32'(ctl), 32'd0);
    chk("flush_valid", 32'(bus.valid_out), 32'd0);
    chk("flush_illegal", 32'(bus.illegal), 32'd0);
    bus.flush = 1'b0;
    tick();
    chk("beq_ctl", 32'(ctl), 32'(mk(5'b01000, 6'b000000, 3'd0, 2'd0, 3'd1)));
    chk("beq_valid", 32'(bus.valid_out), 32'd1);

    ins("DIV then flush", 7'b0110011, 3'b100, 7'b0000001); tick();
    ins("ADD flushed", 7'b0110011, 3'b000, 7'b0000000);
    bus.flush = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.stall) break;
      n++;
      chk("flush_div_valid", 32'(bus.valid_out), 32'd1);
      chk("flush_div_alu", 32'(bus.aluop), 32'(5'b01101));
      tick();
    end
    chk("flush_div_cycles", 32'(n), 32'd3);
    chk("flush_div_done", 32'(ctl), 32'(DIV_CTL));
    tick();
    chk("flush_after_div", 32'(bus.valid_out), 32'd0);
    bus.flush = 1'b0;

    ins("opcode 1111111", 7'b1111111, 3'b000, 7'b0000000); tick();
    chk("bad_op_illegal", 32'(bus.illegal), 32'd1);
    chk("bad_op_valid", 32'(bus.valid_out), 32'd0);
    chk("bad_op_ctl", 32'(ctl), 32'd0);
    ins("LW f3=011", 7'b0000011, 3'b011, 7'b0000000); tick();
    chk("bad_ld_illegal", 32'(bus.illegal), 32'd1);
    chk("bad_ld_we", 32'(bus.writeenable), 32'd0);
    chk("bad_ld_read", 32'(bus.read), 32'd0);
    ins("store f3=011", 7'b0100011, 3'b011, 7'b0000000); tick();
    chk("bad_st_illegal", 32'(bus.illegal), 32'd1);
    chk("bad_st_write", 32'(bus.write), 32'd0);
    ins("ADD", 7'b0110011, 3'b000, 7'b0000000); tick();
    chk("illegal_cleared", 32'(bus.illegal), 32'd0);
    chk("add_valid2", 32'(bus.valid_out), 32'd1);
    bus.instr_valid = 1'b0;
    tick();
    chk("bubble_valid", 32'(bus.valid_out), 32'd0);
    chk("bubble_illegal", 32'(bus.illegal), 32'd0);
    chk("bubble_ctl", 32'(ctl), 32'd0);

    ins("DIV then reset", 7'b0110011, 3'b100, 7'b0000001); tick(); tick();
    chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", 32'(ctl), 32'd0);
    chk("midrst_stall", 32'(bus.stall), 32'd0);
    chk("midrst_busy", 32'(bus.mdiv_busy), 32'd0);
    chk("midrst_valid", 32'(bus.valid_out), 32'd0);
    ins("ADD after reset", 7'b0110011, 3'b000, 7'b0000000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_add", 32'(ctl), 32'(ADD_CTL));
    chk("post_rst_stall", 32'(bus.stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
